hora_bcd_display: RTL and testbench
===================================

// Module: hora_bcd_display
// PURPOSE
//  Consumer end of the 5-bit hour count (0..23) produced by the hour counter.
//  Samples the binary count on a valid strobe and converts it to two BCD digits
//  with a sequential double-dabble FSM. Time-multiplexes the tens and units
//  digits onto a 2-digit common-anode 7-segment display.
//  Sits between the time-keeping counters and the board display pins.
// PARAMETERS
//  REFRESH_DIV  50000  clk cycles each digit is lit; legal range 2..65535
//  MAX_VAL      23     largest legal input value; anything above it is out-of-range
// PORTS
//  clk          in   1  system clock, single clock domain
//  reset_clk    in   1  synchronous reset, active-high
//  conta_in     in   5  binary hour value
//  conta_valid  in   1  1-cycle strobe: sample conta_in
//  busy         out  1  conversion in progress; conta_valid is ignored while high
//  bcd_dec      out  4  tens digit (registered)
//  bcd_uni      out  4  units digit (registered)
//  rango_err    out  1  last accepted value was > MAX_VAL (registered)
//  seg          out  7  segments {g,f,e,d,c,b,a}, active-low
//  an           out  2  digit anodes, active-low; an[0]=units, an[1]=tens
// BEHAVIOUR
//  Reset (reset_clk=1 at a clk edge; synchronous, active-high):
//  - busy=0, bcd_dec=0, bcd_uni=0, rango_err=0.
//  - Refresh counter=0, digit select=units, an=2'b10, seg=7'b1000000 ("0").
//  - Reset dominates every other input, including conta_valid in the same cycle.
//  - Reset mid-conversion aborts it; the partial result is discarded.
//  FSM states: IDLE, SHIFT, DONE.
//  - IDLE: on conta_valid=1, latch conta_in, clear the 8-bit BCD scratch,
//    load iteration count=5, go to SHIFT. busy=1 from the next cycle.
//  - SHIFT (one iteration per cycle): add 3 to each scratch nibble >=5, then
//    shift {scratch,value} left by 1 and decrement the count. When count
//    reaches 0, go to DONE. Exactly 5 SHIFT cycles.
//  - DONE: write bcd_dec/bcd_uni from the scratch, write rango_err =
//    (latched value > MAX_VAL), go to IDLE. busy drops after this edge.
//  Latency: strobe sampled at edge k; outputs update at edge k+6.
//  busy is high for exactly 6 cycles.
//  conta_valid while busy=1 is dropped, not queued.
//  A strobe in the same cycle busy falls (IDLE re-entered) is accepted.
//  Out-of-range values (24..31) still convert; e.g. 31 -> bcd 3,1, rango_err=1.
//  While rango_err=1 both digits display "-" (seg=7'b0111111).
//  Scan:
//  - Refresh counter counts 0..REFRESH_DIV-1 and wraps to 0.
//  - On wrap, the digit select toggles.
//  - an and seg are registered together, so no ghosting cycle occurs.
//  - Units digit: an=2'b10, seg=enc(bcd_uni). Tens digit: an=2'b01, seg=enc(bcd_dec).
//  - No leading-zero blanking: hour 9 shows "09".
//  - The scan runs continuously, independent of the conversion FSM.
//  - Displayed values change only on the DONE edge.
//  - BCD codes 10..15 are never produced; enc() maps them to all-off (7'b1111111).
// STRUCTURE
//  Shared package/include holds:
//  - 7-seg code constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF).
//  - FSM state encodings.
//  - HORA_MAX=23, shared with the hour counter.
//  One combinational sub-module: bcd_a_7seg (4-bit BCD -> 7-bit active-low segments).
//  Instantiate it once, after the digit mux.
// TESTING (bench with REFRESH_DIV=4)
//  1. Reset -> busy=0, bcd=0/0, an=10, seg=1000000; hold 20 cycles:
//     an alternates every 4 cycles.
//  2. conta_in=23, valid 1 cycle -> busy high 6 cycles; bcd_dec=2, bcd_uni=3,
//     rango_err=0; an=01 shows 0100100, an=10 shows 0110000.
//  3. Sweep 0..23 back-to-back, each strobe issued when busy=0 ->
//     bcd equals value/10 and value%10 for every value.
//  4. Strobe 5, then strobe 17 at cycle +2 -> 17 is ignored; final bcd=0/5.
//  5. Strobe 31 -> bcd=3/1, rango_err=1, seg=0111111 on both digits;
//     a following strobe of 8 clears rango_err.
//  6. Strobe 19, assert reset_clk at cycle +3 -> busy=0 the next cycle;
//     bcd=0/0; no later update.

Source files
------------

// File: rtl/hora_bcd_display_pkg.sv
`default_nettype none
// ============================================================================
// Module : hora_bcd_display_pkg
// Brief  : Shared constants for the hour display path (7-seg codes, FSM states).
// Rev    : 1.0 - initial release
// ============================================================================
package hora_bcd_display_pkg;

    localparam logic [4:0] HORA_MAX   = 5'd23;
    localparam logic [2:0] ITER_COUNT = 3'd5;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

endpackage
`default_nettype wire

// File: rtl/hora_bcd_display_bcd_a_7seg.sv
`default_nettype none
// ============================================================================
// Module : bcd_a_7seg
// Brief  : 4-bit BCD digit to active-low 7-segment pattern.
// Rev    : 1.0 - initial release
// ============================================================================
module bcd_a_7seg
    import hora_bcd_display_pkg::*;
(
    input  logic [3:0] bcd_in,
    output logic [6:0] seg_out
);

    always_comb begin
        seg_out = SEG_OFF;
        case (bcd_in)
            4'd0:    seg_out = SEG_0;
            4'd1:    seg_out = SEG_1;
            4'd2:    seg_out = SEG_2;
            4'd3:    seg_out = SEG_3;
            4'd4:    seg_out = SEG_4;
            4'd5:    seg_out = SEG_5;
            4'd6:    seg_out = SEG_6;
            4'd7:    seg_out = SEG_7;
            4'd8:    seg_out = SEG_8;
            4'd9:    seg_out = SEG_9;
            default: seg_out = SEG_OFF;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/hora_bcd_display.sv
`default_nettype none
// ============================================================================
// Module : hora_bcd_display
// Brief  : Hour value to BCD (sequential double-dabble) and 2-digit 7-seg scan.
// Rev    : 1.0 - initial release
// ============================================================================
module hora_bcd_display
    import hora_bcd_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned MAX_VAL     = 32'(HORA_MAX)
) (
    input  logic       clk,
    input  logic       reset_clk,
    input  logic [4:0] conta_in,
    input  logic       conta_valid,
    output logic       busy,
    output logic [3:0] bcd_dec,
    output logic [3:0] bcd_uni,
    output logic       rango_err,
    output logic [6:0] seg,
    output logic [1:0] an
);

    conv_state_e state_q, state_d;
    logic [4:0]  shreg_q, shreg_d;
    logic [7:0]  scratch_q, scratch_d;
    logic [7:0]  scratch_adj;
    logic [2:0]  iter_q, iter_d;
    logic        err_pend_q, err_pend_d;
    logic [3:0]  bcd_dec_q, bcd_dec_d;
    logic [3:0]  bcd_uni_q, bcd_uni_d;
    logic        rango_err_q, rango_err_d;

    logic [15:0] refresh_q, refresh_d;
    logic        sel_q, sel_d;
    logic [1:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  digit_mux;
    logic [6:0]  seg_enc;
    logic        refresh_last;

    always_comb begin
        scratch_adj[3:0] = (scratch_q[3:0] >= 4'd5) ? scratch_q[3:0] + 4'd3 : scratch_q[3:0];
        scratch_adj[7:4] = (scratch_q[7:4] >= 4'd5) ? scratch_q[7:4] + 4'd3 : scratch_q[7:4];
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        scratch_d   = scratch_q;
        iter_d      = iter_q;
        err_pend_d  = err_pend_q;
        bcd_dec_d   = bcd_dec_q;
        bcd_uni_d   = bcd_uni_q;
        rango_err_d = rango_err_q;
        case (state_q)
            ST_IDLE: begin
                if (conta_valid) begin
                    shreg_d    = conta_in;
                    scratch_d  = 8'd0;
                    iter_d     = ITER_COUNT;
                    // The shift register is consumed, so range is judged at capture
                    err_pend_d = (32'(conta_in) > MAX_VAL);
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {scratch_d, shreg_d} = {scratch_adj, shreg_q} << 1;
                iter_d = iter_q - 3'd1;
                if (iter_q == 3'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_dec_d   = scratch_q[7:4];
                bcd_uni_d   = scratch_q[3:0];
                rango_err_d = err_pend_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Scan registers are fed from next-state digits so the display tracks the DONE edge
    always_comb begin
        refresh_last = (refresh_q == 16'(REFRESH_DIV - 1));
        refresh_d    = refresh_last ? 16'd0 : refresh_q + 16'd1;
        sel_d        = sel_q ^ refresh_last;
        digit_mux    = sel_d ? bcd_dec_d : bcd_uni_d;
        an_d         = sel_d ? 2'b01 : 2'b10;
        seg_d        = rango_err_d ? SEG_DASH : seg_enc;
    end

    bcd_a_7seg u_bcd_a_7seg (
        .bcd_in  (digit_mux),
        .seg_out (seg_enc)
    );

    always_ff @(posedge clk) begin
        if (reset_clk) begin
            state_q     <= ST_IDLE;
            shreg_q     <= 5'd0;
            scratch_q   <= 8'd0;
            iter_q      <= 3'd0;
            err_pend_q  <= 1'b0;
            bcd_dec_q   <= 4'd0;
            bcd_uni_q   <= 4'd0;
            rango_err_q <= 1'b0;
            refresh_q   <= 16'd0;
            sel_q       <= 1'b0;
            an_q        <= 2'b10;
            seg_q       <= SEG_0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            scratch_q   <= scratch_d;
            iter_q      <= iter_d;
            err_pend_q  <= err_pend_d;
            bcd_dec_q   <= bcd_dec_d;
            bcd_uni_q   <= bcd_uni_d;
            rango_err_q <= rango_err_d;
            refresh_q   <= refresh_d;
            sel_q       <= sel_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign bcd_dec   = bcd_dec_q;
    assign bcd_uni   = bcd_uni_q;
    assign rango_err = rango_err_q;
    assign seg       = seg_q;
    assign an        = an_q;

endmodule
`default_nettype wire

// File: tb/tb_hora_bcd_display.sv
`default_nettype none
// ============================================================================
// Module : tb_hora_bcd_display
// Brief  : Randomized self-checking bench for hora_bcd_display (REFRESH_DIV=4).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_hora_bcd_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset_clk = 1'b1;
    logic [4:0] conta_in = 5'd0;
    logic       conta_valid = 1'b0;
    logic       busy;
    logic [3:0] bcd_dec;
    logic [3:0] bcd_uni;
    logic       rango_err;
    logic [6:0] seg;
    logic [1:0] an;

    int total = 0;
    int bad   = 0;
    int scan_edges = 0;
    int exp_dec = 0;
    int exp_uni = 0;
    bit exp_err = 1'b0;

    logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    hora_bcd_display #(.REFRESH_DIV(DIV), .MAX_VAL(23)) dut (
        .clk         (clk),
        .reset_clk   (reset_clk),
        .conta_in    (conta_in),
        .conta_valid (conta_valid),
        .busy        (busy),
        .bcd_dec     (bcd_dec),
        .bcd_uni     (bcd_uni),
        .rango_err   (rango_err),
        .seg         (seg),
        .an          (an)
    );

    always #5 clk = ~clk;

    // Edges since the last reset edge; the digit select flips every DIV of them
    always @(posedge clk) begin
        if (reset_clk) scan_edges <= 0;
        else           scan_edges <= scan_edges + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_disp(input string tag);
        logic [1:0] e_an;
        int         digit;
        logic [6:0] e_seg;
        e_an  = (((scan_edges / DIV) % 2) == 1) ? 2'b01 : 2'b10;
        digit = (e_an == 2'b01) ? exp_dec : exp_uni;
        e_seg = exp_err ? 7'b0111111 : seg_tbl[digit];
        check_eq({tag, "_an"}, 32'(an), 32'(e_an));
        check_eq({tag, "_seg"}, 32'(seg), 32'(e_seg));
    endtask

    task automatic check_result(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_dec"}, 32'(bcd_dec), 32'(exp_dec));
        check_eq({tag, "_uni"}, 32'(bcd_uni), 32'(exp_uni));
        check_eq({tag, "_err"}, 32'(rango_err), 32'(exp_err));
        check_disp(tag);
    endtask

    // One strobe; optionally sprinkle extra strobes while busy, which must be dropped
    task automatic convert(input int v, input bit noise);
        conta_in    = 5'(v);
        conta_valid = 1'b1;
        tick();
        conta_valid = 1'b0;
        for (int j = 0; j < 6; j++) begin
            check_eq("busy_hi", 32'(busy), 1);
            check_eq("hold_uni", 32'(bcd_uni), 32'(exp_uni));
            if (noise && $urandom_range(0, 1) == 1) begin
                conta_in    = 5'($urandom);
                conta_valid = 1'b1;
            end
            tick();
            conta_valid = 1'b0;
        end
        exp_dec = v / 10;
        exp_uni = v % 10;
        exp_err = (v > 23);
        check_result("conv");
    endtask

    initial begin
        // 1. Reset state and free-running scan
        reset_clk = 1'b1;
        repeat (2) tick();
        reset_clk = 1'b0;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_dec", 32'(bcd_dec), 0);
        check_eq("rst_uni", 32'(bcd_uni), 0);
        check_eq("rst_err", 32'(rango_err), 0);
        check_eq("rst_an", 32'(an), 32'(2'b10));
        check_eq("rst_seg", 32'(seg), 32'(7'b1000000));
        for (int i = 0; i < 20; i++) begin
            tick();
            check_disp("scan");
        end

        // 2. Hour 23
        convert(23, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_disp("show23");
        end

        // 3. Sweep of all legal hours with random gaps and busy-time noise
        for (int v = 0; v <= 23; v++) begin
            convert(v, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick();
        end

        // 4. Second strobe two cycles into a conversion is dropped
        conta_in = 5'd5; conta_valid = 1'b1;
        tick();
        conta_valid = 1'b0;
        tick();
        conta_in = 5'd17; conta_valid = 1'b1;
        tick();
        conta_valid = 1'b0;
        repeat (4) tick();
        exp_dec = 0; exp_uni = 5; exp_err = 1'b0;
        check_result("drop");
        repeat (8) tick();
        check_result("drop_late");

        // 5. Out-of-range value shows dashes, then clears
        convert(31, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_disp("dash");
        end
        convert(8, 1'b0);

        // Random values across the full 5-bit range
        for (int i = 0; i < 30; i++) begin
            convert(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) tick();
            check_disp("rnd_idle");
        end

        // 6. Reset mid-conversion aborts it
        conta_in = 5'd19; conta_valid = 1'b1;
        tick();
        conta_valid = 1'b0;
        repeat (2) tick();
        reset_clk = 1'b1;
        tick();
        reset_clk = 1'b0;
        exp_dec = 0; exp_uni = 0; exp_err = 1'b0;
        check_result("abort");
        check_eq("abort_an", 32'(an), 32'(2'b10));
        repeat (10) tick();
        check_result("abort_late");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
